// File: rtl/sram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sram_rr_arbiter
// Brief   : Round-robin sharing of one single-port SRAM among NUM_PORTS
//           requesters, with read responses routed back via a port-ID pipeline.
// Revision: 1.0
// ============================================================================
module sram_rr_arbiter #(
  parameter  int unsigned NUM_PORTS    = 2,
  parameter  int unsigned DATA_WIDTH   = 64,
  parameter  int unsigned NUM_WORDS    = 1024,
  parameter  int unsigned READ_LATENCY = 1,
  localparam int unsigned AW           = $clog2(NUM_WORDS),
  localparam int unsigned BW           = (DATA_WIDTH + 7) / 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_PORTS-1:0]            req_valid_i,
  output logic [NUM_PORTS-1:0]            req_ready_o,
  input  logic [NUM_PORTS-1:0]            req_we_i,
  input  logic [NUM_PORTS*AW-1:0]         req_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata_i,
  input  logic [NUM_PORTS*BW-1:0]         req_be_i,
  output logic [NUM_PORTS-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]           rsp_rdata_o,
  output logic                            sram_req_o,
  output logic                            sram_we_o,
  output logic [AW-1:0]                   sram_addr_o,
  output logic [DATA_WIDTH-1:0]           sram_wdata_o,
  output logic [BW-1:0]                   sram_be_o,
  input  logic [DATA_WIDTH-1:0]           sram_rdata_i
);

  localparam int unsigned c_id_w = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [c_id_w-1:0]                    r_ptr;
  logic [c_id_w-1:0]                    w_idx;
  logic [c_id_w-1:0]                    w_gnt_id;
  logic                                 w_gnt_any;
  logic [NUM_PORTS-1:0]                 w_grant;
  logic                                 w_rd_issue;
  logic [READ_LATENCY-1:0]              r_vld;
  logic [READ_LATENCY-1:0][c_id_w-1:0]  r_id;

  // Scan ports starting at the pointer; the first valid one wins.
  always_comb begin
    w_idx     = '0;
    w_gnt_id  = '0;
    w_gnt_any = 1'b0;
    w_grant   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_idx = c_id_w'((32'(r_ptr) + 32'(i)) % 32'(NUM_PORTS));
      if (!w_gnt_any && req_valid_i[w_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = w_idx;
      end
    end
    if (w_gnt_any && rst_ni) begin
      w_grant[w_gnt_id] = 1'b1;
    end
  end

  assign req_ready_o  = w_grant;
  assign sram_req_o   = rst_ni & (|req_valid_i);
  assign sram_we_o    = req_we_i[w_gnt_id];
  assign sram_addr_o  = req_addr_i[32'(w_gnt_id)*AW +: AW];
  assign sram_wdata_o = req_wdata_i[32'(w_gnt_id)*DATA_WIDTH +: DATA_WIDTH];
  assign sram_be_o    = req_be_i[32'(w_gnt_id)*BW +: BW];
  assign w_rd_issue   = sram_req_o & ~sram_we_o;

  generate
    if (NUM_PORTS == 1) begin : g_ptr_single
      assign r_ptr = '0;
    end else begin : g_ptr_rr
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          r_ptr <= '0;
        end else if (w_gnt_any) begin
          r_ptr <= (32'(w_gnt_id) == NUM_PORTS - 1) ? '0 : w_gnt_id + 1'b1;
        end
      end
    end
  endgenerate

  // In-flight read tags; clearing only the valids is enough to drop them on reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_rd_issue;
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_vld[s] <= r_vld[s-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    r_id[0] <= w_gnt_id;
    for (int s = 1; s < READ_LATENCY; s++) begin
      r_id[s] <= r_id[s-1];
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (r_vld[READ_LATENCY-1]) begin
      rsp_valid_o[r_id[READ_LATENCY-1]] = 1'b1;
    end
  end

  assign rsp_rdata_o = sram_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_sram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_rr_arbiter
// Brief   : Scoreboard bench: A is 3 ports / latency 1, B is 2 ports / latency 2.
// Revision: 1.0
// ============================================================================
module tb_sram_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  vld;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // Instance A
  logic         rst_a_n;
  logic [2:0]   va, wea, ready_a, rsp_valid_a;
  logic [11:0]  addra;
  logic [191:0] wdataa;
  logic [23:0]  bea;
  logic [63:0]  rsp_rdata_a;
  logic         sa_req, sa_we;
  logic [3:0]   sa_addr;
  logic [63:0]  sa_wdata, sa_rdata;
  logic [7:0]   sa_be;

  // Instance B
  logic         rst_b_n;
  logic [1:0]   vb, web, ready_b, rsp_valid_b;
  logic [7:0]   addrb;
  logic [127:0] wdatab;
  logic [15:0]  beb;
  logic [63:0]  rsp_rdata_b;
  logic         sb_req, sb_we;
  logic [3:0]   sb_addr;
  logic [63:0]  sb_wdata, sb_rdata;
  logic [7:0]   sb_be;

  sram_rr_arbiter #(
    .NUM_PORTS(3), .DATA_WIDTH(64), .NUM_WORDS(16), .READ_LATENCY(1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_a_n),
    .req_valid_i(va), .req_ready_o(ready_a), .req_we_i(wea),
    .req_addr_i(addra), .req_wdata_i(wdataa), .req_be_i(bea),
    .rsp_valid_o(rsp_valid_a), .rsp_rdata_o(rsp_rdata_a),
    .sram_req_o(sa_req), .sram_we_o(sa_we), .sram_addr_o(sa_addr),
    .sram_wdata_o(sa_wdata), .sram_be_o(sa_be), .sram_rdata_i(sa_rdata)
  );

  sram_rr_arbiter #(
    .NUM_PORTS(2), .DATA_WIDTH(64), .NUM_WORDS(16), .READ_LATENCY(2)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_b_n),
    .req_valid_i(vb), .req_ready_o(ready_b), .req_we_i(web),
    .req_addr_i(addrb), .req_wdata_i(wdatab), .req_be_i(beb),
    .rsp_valid_o(rsp_valid_b), .rsp_rdata_o(rsp_rdata_b),
    .sram_req_o(sb_req), .sram_we_o(sb_we), .sram_addr_o(sb_addr),
    .sram_wdata_o(sb_wdata), .sram_be_o(sb_be), .sram_rdata_i(sb_rdata)
  );

  // Behavioural SRAMs: A has one output register, B has two.
  logic [63:0] mem_a [16];
  logic [63:0] mem_b [16];
  logic [63:0] rd_a, rd_b1, rd_b2;

  always @(posedge clk) begin
    if (sa_req) begin
      if (sa_we) begin
        for (int b = 0; b < 8; b++)
          if (sa_be[b]) mem_a[sa_addr][b*8 +: 8] <= sa_wdata[b*8 +: 8];
      end else begin
        rd_a <= mem_a[sa_addr];
      end
    end
  end
  assign sa_rdata = rd_a;

  always @(posedge clk) begin
    if (sb_req) begin
      if (sb_we) begin
        for (int b = 0; b < 8; b++)
          if (sb_be[b]) mem_b[sb_addr][b*8 +: 8] <= sb_wdata[b*8 +: 8];
      end else begin
        rd_b1 <= mem_b[sb_addr];
      end
    end
    rd_b2 <= rd_b1;
  end
  assign sb_rdata = rd_b2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_a(input int p, input logic we, input logic [3:0] addr,
                       input logic [63:0] d, input logic [7:0] be);
    va[p]            = 1'b1;
    wea[p]           = we;
    addra[p*4 +: 4]  = addr;
    wdataa[p*64 +: 64] = d;
    bea[p*8 +: 8]    = be;
  endtask

  task automatic set_b(input int p, input logic we, input logic [3:0] addr,
                       input logic [63:0] d, input logic [7:0] be);
    vb[p]            = 1'b1;
    web[p]           = we;
    addrb[p*4 +: 4]  = addr;
    wdatab[p*64 +: 64] = d;
    beb[p*8 +: 8]    = be;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid_a != 3'b000) begin
        n_checks++;
        if (qa.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_a_unexpected: got valid %b, expected none (cycle %0d)", rsp_valid_a, cyc);
        end else begin
          e = qa.pop_front();
          if (rsp_valid_a !== e.vld || rsp_rdata_a !== e.data || cyc != e.due) begin
            n_fail++;
            $display("FAIL rsp_a: got valid %b data %h cycle %0d, expected valid %b data %h cycle %0d",
                     rsp_valid_a, rsp_rdata_a, cyc, e.vld, e.data, e.due);
          end
        end
      end else if (qa.size() != 0 && qa[0].due <= cyc) begin
        n_checks++;
        n_fail++;
        e = qa.pop_front();
        $display("FAIL rsp_a_missing: got valid 000, expected valid %b at cycle %0d", e.vld, e.due);
      end

      if (rsp_valid_b != 2'b00) begin
        n_checks++;
        if (qb.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_b_unexpected: got valid %b, expected none (cycle %0d)", rsp_valid_b, cyc);
        end else begin
          e = qb.pop_front();
          if ({1'b0, rsp_valid_b} !== e.vld || rsp_rdata_b !== e.data || cyc != e.due) begin
            n_fail++;
            $display("FAIL rsp_b: got valid %b data %h cycle %0d, expected valid %b data %h cycle %0d",
                     rsp_valid_b, rsp_rdata_b, cyc, e.vld[1:0], e.data, e.due);
          end
        end
      end else if (qb.size() != 0 && qb[0].due <= cyc) begin
        n_checks++;
        n_fail++;
        e = qb.pop_front();
        $display("FAIL rsp_b_missing: got valid 00, expected valid %b at cycle %0d", e.vld[1:0], e.due);
      end
    end
  endtask

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    va = '1; wea = '0; addra = '0; wdataa = '0; bea = '0;
    vb = '1; web = '0; addrb = '0; wdatab = '0; beb = '0;

    // Reset held with every port requesting
    repeat (3) begin
      sample();
      chk("rst_ready_a", 64'(ready_a), 64'(3'b000));
      chk("rst_sram_req_a", 64'(sa_req), 64'(1'b0));
      chk("rst_ready_b", 64'(ready_b), 64'(2'b00));
      chk("rst_sram_req_b", 64'(sb_req), 64'(1'b0));
      step();
    end
    va = '0; vb = '0;
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    fork
      monitor();
    join_none
    sample();
    chk("post_rst_rsp_a", 64'(rsp_valid_a), 64'(3'b000));
    chk("post_rst_rsp_b", 64'(rsp_valid_b), 64'(2'b00));
    step();

    // ---------------- Instance A: 3 ports, latency 1 ----------------
    set_a(0, 1'b1, 4'd5, 64'hDEADBEEF_01234567, 8'hFF);
    sample(); chk("a_wr5_grant", 64'(ready_a), 64'(3'b001)); step();

    va = '0; set_a(0, 1'b0, 4'd5, 64'h0, 8'h00);
    sample(); chk("a_rd5_grant", 64'(ready_a), 64'(3'b001));
    qa.push_back('{3'b001, 64'hDEADBEEF_01234567, cyc + 1}); step();

    va = '0; set_a(1, 1'b1, 4'd7, 64'h0, 8'hFF);
    sample(); chk("a_wr7_full_grant", 64'(ready_a), 64'(3'b010)); step();

    va = '0; set_a(1, 1'b1, 4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    sample(); chk("a_wr7_be_grant", 64'(ready_a), 64'(3'b010)); step();

    va = '0; set_a(2, 1'b0, 4'd7, 64'h0, 8'h00);
    sample(); chk("a_rd7_grant", 64'(ready_a), 64'(3'b100));
    qa.push_back('{3'b100, 64'h0000_0000_FFFF_FFFF, cyc + 1}); step();

    for (int p = 0; p < 3; p++) begin
      va = '0; set_a(p, 1'b1, 4'(p), 64'hA0 + 64'(p), 8'hFF);
      sample(); chk("a_seed_grant", 64'(ready_a), 64'(3'b001) << p); step();
    end

    // All three ports request continuously: strict rotation from port 0
    va = '0;
    for (int p = 0; p < 3; p++) set_a(p, 1'b0, 4'(p), 64'h0, 8'h00);
    for (int k = 0; k < 9; k++) begin
      sample(); chk("a_fair_grant", 64'(ready_a), 64'(3'b001) << (k % 3));
      qa.push_back('{3'(1 << (k % 3)), 64'hA0 + 64'(k % 3), cyc + 1});
      step();
    end
    va = '0;
    repeat (2) step();

    // ---------------- Instance B: 2 ports, latency 2 ----------------
    set_b(0, 1'b1, 4'd3, 64'h3333_3333_3333_3333, 8'hFF);
    sample(); chk("b_wr3_grant", 64'(ready_b), 64'(2'b01)); step();

    vb = '0; set_b(0, 1'b1, 4'd4, 64'h4444_4444_4444_4444, 8'hFF);
    sample(); chk("b_wr4_grant", 64'(ready_b), 64'(2'b01)); step();

    vb = '0; set_b(1, 1'b0, 4'd3, 64'h0, 8'h00);
    sample(); chk("b_lat2_rd_p1", 64'(ready_b), 64'(2'b10));
    qb.push_back('{3'b010, 64'h3333_3333_3333_3333, cyc + 2}); step();

    vb = '0; set_b(0, 1'b0, 4'd4, 64'h0, 8'h00);
    sample(); chk("b_lat2_rd_p0", 64'(ready_b), 64'(2'b01));
    qb.push_back('{3'b001, 64'h4444_4444_4444_4444, cyc + 2}); step();

    vb = '0; set_b(1, 1'b1, 4'd6, 64'h66, 8'hFF);
    sample(); chk("b_lone_p1_grant", 64'(ready_b), 64'(2'b10)); step();

    vb = '0; set_b(0, 1'b0, 4'd3, 64'h0, 8'h00); set_b(1, 1'b0, 4'd4, 64'h0, 8'h00);
    sample(); chk("b_ptr_after_lone", 64'(ready_b), 64'(2'b01));
    qb.push_back('{3'b001, 64'h3333_3333_3333_3333, cyc + 2}); step();

    vb = '0; set_b(1, 1'b0, 4'd4, 64'h0, 8'h00);
    sample(); chk("b_waiting_p1", 64'(ready_b), 64'(2'b10));
    qb.push_back('{3'b010, 64'h4444_4444_4444_4444, cyc + 2}); step();

    vb = '0;
    repeat (3) step();

    // Reset while a read is in flight: that read must never respond
    set_b(0, 1'b0, 4'd3, 64'h0, 8'h00);
    sample(); chk("b_pre_rst_grant", 64'(ready_b), 64'(2'b01)); step();

    vb = '0; rst_b_n = 1'b0;
    sample(); chk("b_mid_rst_ready", 64'(ready_b), 64'(2'b00)); step();

    rst_b_n = 1'b1;
    set_b(0, 1'b0, 4'd4, 64'h0, 8'h00); set_b(1, 1'b0, 4'd3, 64'h0, 8'h00);
    sample();
    chk("b_rst_drop_t2", 64'(rsp_valid_b), 64'(2'b00));
    chk("b_ptr_after_rst", 64'(ready_b), 64'(2'b01));
    qb.push_back('{3'b001, 64'h4444_4444_4444_4444, cyc + 2}); step();

    vb = '0; set_b(1, 1'b0, 4'd3, 64'h0, 8'h00);
    sample();
    chk("b_rst_drop_t3", 64'(rsp_valid_b), 64'(2'b00));
    chk("b_post_rst_p1", 64'(ready_b), 64'(2'b10));
    qb.push_back('{3'b010, 64'h3333_3333_3333_3333, cyc + 2}); step();

    vb = '0;
    repeat (4) step();
    sample();
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_rr_arbiter.md
# sram_rr_arbiter

Round-robin arbiter that shares one single-port SRAM macro (byte-enabled, read latency 1 or 2 cycles) among NUM_PORTS requesters. Each requester sees a valid/ready request channel and a non-stallable read-response channel. The arbiter tracks in-flight reads with a port-ID shift pipeline and routes each read result back to the port that issued it. It sits between the cache/DMA clients and the SRAM behavioural model or FPGA macro.

## Interface
- NUM_PORTS, default 2: number of requesters, ≥1.
- DATA_WIDTH, default 64: SRAM word width.
- NUM_WORDS, default 1024: SRAM depth. AW = $clog2(NUM_WORDS). BW = (DATA_WIDTH+7)/8.
- READ_LATENCY, default 1: cycles from SRAM read request to valid sram_rdata_i. Legal values are 1 and 2; 2 corresponds to the macro with output registers enabled.
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_ni  in  1  reset, synchronous and active-low.
- req_valid_i  in  NUM_PORTS  per-port request valid.
- req_ready_o  out  NUM_PORTS  per-port grant; one-hot or all-zero.
- req_we_i  in  NUM_PORTS  per-port write enable (1 = write, 0 = read).
- req_addr_i  in  NUM_PORTS×AW  per-port word address.
- req_wdata_i  in  NUM_PORTS×DATA_WIDTH  per-port write data.
- req_be_i  in  NUM_PORTS×BW  per-port byte enables.
- rsp_valid_o  out  NUM_PORTS  per-port read-data valid; one-hot or all-zero.
- rsp_rdata_o  out  DATA_WIDTH  read data, shared by all ports, qualified by rsp_valid_o.
- sram_req_o, sram_we_o  out  1  SRAM request and write enable.
- sram_addr_o  out  AW  SRAM address.
- sram_wdata_o  out  DATA_WIDTH  SRAM write data.
- sram_be_o  out  BW  SRAM byte enables.
- sram_rdata_i  in  DATA_WIDTH  SRAM read data.

## Operation
- **Handshake:** A request transfers in a cycle where req_valid_i[p] and req_ready_o[p] are both 1. Once valid is raised, the requester holds valid, we, addr, wdata and be stable until the transfer.
- **Arbitration:** Combinational round-robin.
  - Priority pointer ptr has width max(1,$clog2(NUM_PORTS)).
  - The grant goes to the first valid port at or after ptr, wrapping from NUM_PORTS-1 to 0.
  - After any grant to port g, ptr is set to (g+1) mod NUM_PORTS. With no grant, ptr holds.
  - req_ready_o depends only on req_valid_i and ptr. It never depends on any ready signal.
- **SRAM drive:**
  - sram_req_o = |req_valid_i.
  - sram_we_o, sram_addr_o, sram_wdata_o and sram_be_o are muxed from the granted port. They are don't-care when sram_req_o = 0.
  - A write issues in its grant cycle and produces no response.
- **Read tracking:**
  - A READ_LATENCY-deep pipeline of {valid, port-id} entries.
  - The stage-0 input is {granted && !we, g}.
  - At the output stage: rsp_valid_o[id] = entry valid, and rsp_rdata_o = sram_rdata_i.
  - The arbiter does not buffer data; rsp_rdata_o is a pass-through.
- **Throughput:** One SRAM access per cycle, with no bubbles between back-to-back grants, including read→write→read sequences.
- **Ordering:** SRAM order equals grant order. A write granted at cycle t is visible to a read granted at t+1 or later.
- **Single port:** When NUM_PORTS = 1, ptr is constant 0 and req_ready_o = req_valid_i.

## Timing
- **Reset values:**
  - While rst_ni = 0, req_ready_o = 0 and sram_req_o = 0.
  - On the reset edge: ptr ← 0 and all pipeline valids ← 0.
  - rsp_valid_o = 0 from the first cycle after the reset edge until READ_LATENCY cycles after the first post-reset read grant.
- **Read latency:** A read granted at cycle t gives rsp_valid_o[p] = 1 at cycle t+READ_LATENCY, with rsp_rdata_o equal to the data at that address.
- **Back-pressure:** Responses cannot be back-pressured. The requester must accept rsp_valid_o in the cycle it is asserted.
- **Reset mid-operation:** Every in-flight read is discarded. No rsp_valid_o is asserted for a read granted before the reset edge.
- **Simultaneous events:** When all ports request every cycle, grants rotate strictly 0,1,…,NUM_PORTS-1,0,… Each port is granted exactly once per NUM_PORTS cycles, so the worst-case wait is NUM_PORTS-1 cycles.
- **Pointer after a lone requester:** If port 1 alone is granted, ptr becomes 2 mod N. On the next cycle, port 0 wins over port 1 when both are valid.
- **Same-cycle request and response:** A read response and a new request for the same port in the same cycle are independent and both occur.

## Test plan
- **Reset defaults:** Hold rst_ni = 0 for 3 cycles with all valids high → req_ready_o = 0 and sram_req_o = 0. After release, rsp_valid_o stays 0 until READ_LATENCY cycles after the first read grant.
- **Single-port write then read:** N=2, L=1. Port 0 writes 0xDEADBEEF_01234567 to addr 5 with be=0xFF, then reads addr 5 → rsp_valid_o = 2'b01 one cycle after the read grant, rsp_rdata_o = 0xDEADBEEF_01234567.
- **Byte-enable merge:** Write 0x0 to addr 7 with be=0xFF, then write 0xFFFF_FFFF_FFFF_FFFF with be=0x0F, then read addr 7 → rsp_rdata_o = 0x0000_0000_FFFF_FFFF.
- **Fairness:** N=3. All ports hold valid reads of addrs 0/1/2 for 9 cycles → grant sequence 0,1,2,0,1,2,0,1,2. Each rsp_valid_o one-hot is correctly tagged.
- **Latency 2:** L=2, N=2. Port 1 reads addr 3 at cycle t and port 0 reads addr 4 at t+1 → rsp_valid_o = 2'b10 at t+2 and 2'b01 at t+3, each with the correct data.
- **Reset mid-operation:** L=2. Read granted at cycle t, rst_ni = 0 at t+1 → no rsp_valid_o at t+2 or later. After reset, ptr = 0, so port 0 wins a simultaneous 0/1 request.
